// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared types, constants and helpers for the BCD display scanning logic.
//   bcd_t      : one packed BCD digit (4 bits)
//   BCD_MAX    : largest legal BCD code; anything above is flagged as an error
//   MAX_DIGITS : widest digit-enable vector the helper function can produce
//   onehot()   : index -> one-hot vector (MAX_DIGITS wide); callers keep the
//                low bits they need
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam int   MAX_DIGITS = 8;
    localparam int   IDX_MAX_W  = 3;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [IDX_MAX_W-1:0] index);
        logic [MAX_DIGITS-1:0] vec;
        vec        = '0;
        vec[index] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/refresh_tick.sv
// -----------------------------------------------------------------------------
// refresh_tick
// Terminal-count divider. Counts 0..DIV-1 while en is high and wraps; tick is
// high during the cycle in which the count sits at DIV-1, so it is exactly one
// cycle wide per DIV enabled cycles. The running count is exported so a parent
// can also detect the first cycle of a period (count == 0).
//
// Parameters:
//   DIV   : period in clock cycles (>= 2)
// Ports:
//   clk   : in  clock, rising edge
//   rst_n : in  synchronous reset, active low (count returns to 0)
//   en    : in  count enable
//   count : out current count value
//   tick  : out one-cycle terminal-count strobe
// -----------------------------------------------------------------------------
module refresh_tick #(
    parameter int DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic [$clog2(DIV)-1:0] count,
    output logic                   tick
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_end;

    always_comb begin
        at_end = (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = cnt_q;
        if (en) begin
            cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign tick  = en & at_end;

endmodule

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
// Time-multiplexes a packed multi-digit BCD value onto one shared 7-segment
// decoder. Each digit slot is selected for REFRESH_DIV cycles in turn; the
// selected slot's code goes to digit_bcd and a one-hot enable to digit_en.
// New values land in a shadow register and are copied to the displayed
// register only when the scan wraps back to slot 0, so a frame never mixes
// digits of two different values.
//
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, a non-zero slot whose digit and all
//                           higher digits are 0 has its enable forced low.
//                           Slot 0 is always shown. Sequencing is unchanged.
//
// Parameters:
//   NUM_DIGITS  : number of digit slots (2..8)
//   REFRESH_DIV : cycles each slot stays selected (>= 2)
// Ports:
//   clk         : in  clock, rising edge
//   rst_n       : in  synchronous reset, active low
//   load        : in  one-cycle strobe, capture bcd_in
//   bcd_in      : in  packed BCD, digit 0 in [3:0]
//   digit_bcd   : out code of the selected digit (to the decoder)
//   digit_en    : out one-hot active-high digit enable
//   frame_start : out one-cycle pulse with the first cycle of slot 0
//   pending     : out shadow holds a value not yet displayed
//   bcd_err     : out selected nibble is greater than 9
// -----------------------------------------------------------------------------
module bcd_display_scanner
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start,
    output logic                    pending,
    output logic                    bcd_err
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;

    // ------------------------------------------------------------------
    // Refresh timing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_tick_s;

    refresh_tick #(
        .DIV (REFRESH_DIV)
    ) u_refresh_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .count (refresh_cnt),
        .tick  (refresh_tick_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic [DW-1:0]         display_q,     display_d;
    logic [DW-1:0]         shadow_q,      shadow_d;
    logic                  pending_q,     pending_d;
    bcd_t                  digit_bcd_q,   digit_bcd_d;
    logic [NUM_DIGITS-1:0] digit_en_q,    digit_en_d;
    logic                  frame_start_q, frame_start_d;
    logic                  bcd_err_q,     bcd_err_d;

    logic                  wrap;
    bcd_t                  sel_nib;
    logic [MAX_DIGITS-1:0] oh_full;
    logic                  blank_sel;

    // Displayed value split into digits for indexed selection.
    bcd_t disp_nib [NUM_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign disp_nib[gi] = display_q[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Leading-zero blanking
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[i] is high when digit i and every digit above it are 0.
    logic [NUM_DIGITS:0]   zero_from;
    logic [NUM_DIGITS-1:0] zero_lo;

    assign zero_from[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            assign zero_from[gi] = (disp_nib[gi] == 4'd0) && zero_from[gi+1];
        end
    endgenerate

    assign zero_lo   = zero_from[NUM_DIGITS-1:0];
    // Slot 0 stays lit so an all-zero value still reads "0".
    assign blank_sel = (idx_q != '0) && zero_lo[idx_q];
`else
    assign blank_sel = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        idx_d     = idx_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        // The edge on which the index returns to slot 0 is the frame swap.
        wrap = refresh_tick_s && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (refresh_tick_s) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            shadow_d = bcd_in;
        end

        if (wrap) begin
            // A load coinciding with the swap is newer than the shadow, so it
            // bypasses straight into the display.
            if (load) begin
                display_d = bcd_in;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: driven from the index held before this edge, giving
    // one cycle of latency between index and outputs.
    // ------------------------------------------------------------------
    always_comb begin
        sel_nib       = disp_nib[idx_q];
        oh_full       = onehot(IDX_MAX_W'(idx_q));
        digit_bcd_d   = sel_nib;
        digit_en_d    = blank_sel ? '0 : oh_full[NUM_DIGITS-1:0];
        frame_start_d = (idx_q == '0) && (refresh_cnt == '0);
        bcd_err_d     = (sel_nib > BCD_MAX);
    end

    // Upper one-hot bits exist only when fewer than MAX_DIGITS slots are used.
    logic unused_oh;
    assign unused_oh = ^oh_full;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q         <= '0;
            display_q     <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            digit_bcd_q   <= '0;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
            bcd_err_q     <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            display_q     <= display_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            digit_bcd_q   <= digit_bcd_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
            bcd_err_q     <= bcd_err_d;
        end
    end

    assign digit_bcd   = digit_bcd_q;
    assign digit_en    = digit_en_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;
    assign bcd_err     = bcd_err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
// Directed scoreboard bench for bcd_display_scanner (NUM_DIGITS=4,
// REFRESH_DIV=4). Stimulus pushes one expected frame record per frame; a
// monitor pops a record on every frame_start and compares all outputs for
// every cycle of that frame. Honours LEADING_ZERO_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FL = ND * RD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   bcd_in = '0;
    logic [3:0]    digit_bcd;
    logic [ND-1:0] digit_en;
    logic          frame_start;
    logic          pending;
    logic          bcd_err;

    bcd_display_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .bcd_in      (bcd_in),
        .digit_bcd   (digit_bcd),
        .digit_en    (digit_en),
        .frame_start (frame_start),
        .pending     (pending),
        .bcd_err     (bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  err_mask;
        logic [3:0]  vis_mask;
        int          len;
    } frame_t;

    frame_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    bit     mon_en = 1'b0;

    // vis_blank: slots expected lit when leading-zero blanking is built in.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] err,
                              input logic [3:0] vis_blank, input int len);
        frame_t f;
        f.value    = v;
        f.err_mask = err;
`ifdef LEADING_ZERO_BLANK_EN
        f.vis_mask = vis_blank;
`else
        f.vis_mask = 4'hF;
`endif
        f.len      = len;
        exp_q.push_back(f);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load   = 1'b1;
        bcd_in = v;
        @(negedge clk);
        load   = 1'b0;
        $display("load %h at t=%0t", v, $time);
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_frame: got no frame_start expected one within 64 cycles");
        end
    endtask

    // Monitor / scoreboard
    initial begin
        frame_t     f;
        int         slot;
        int         fid;
        int         bad;
        logic [3:0] exp_bcd;
        logic [3:0] exp_en;
        logic       exp_err;
        logic       exp_fs;
        fid = 0;
        forever begin
            @(negedge clk);
            if (mon_en && frame_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: got frame_start expected no frame");
                end else begin
                    f   = exp_q.pop_front();
                    bad = 0;
                    for (int c = 0; c < f.len; c++) begin
                        if (c > 0) @(negedge clk);
                        slot           = c / RD;
                        exp_bcd        = f.value[slot*4 +: 4];
                        exp_en         = '0;
                        exp_en[slot]   = f.vis_mask[slot];
                        exp_err        = f.err_mask[slot];
                        exp_fs         = (c == 0);
                        n_vec++;
                        if ({digit_bcd, digit_en, bcd_err, frame_start} !==
                            {exp_bcd, exp_en, exp_err, exp_fs}) begin
                            n_err++;
                            bad++;
                            $display("FAIL frame%0d_cyc%0d: got bcd=%h en=%b err=%b fs=%b expected bcd=%h en=%b err=%b fs=%b",
                                     fid, c, digit_bcd, digit_en, bcd_err, frame_start,
                                     exp_bcd, exp_en, exp_err, exp_fs);
                        end
                    end
                    $display("frame %0d value %h checked %0d cycles, %0d bad", fid, f.value, f.len, bad);
                    fid++;
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset state
        step(3);
        chk("rst_digit_bcd",   32'(digit_bcd),   32'h0);
        chk("rst_digit_en",    32'(digit_en),    32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_pending",     32'(pending),     32'h0);
        chk("rst_bcd_err",     32'(bcd_err),     32'h0);

        // Frame 0: display still 0 while 1234 waits in the shadow
        mon_en = 1'b1;
        push_frame(16'h0000, 4'b0000, 4'b0001, FL);
        rst_n = 1'b1;
        wait_frame();
        step(3);
        do_load(16'h1234);
        chk("pending_after_1234", 32'(pending), 32'h1);
        push_frame(16'h1234, 4'b0000, 4'b1111, FL);

        // Frame 1: shows 1234; two loads, last one wins
        wait_frame();
        chk("pending_after_swap1", 32'(pending), 32'h0);
        step(2);
        do_load(16'h1111);
        chk("pending_after_1111", 32'(pending), 32'h1);
        step(3);
        do_load(16'h2222);
        chk("pending_after_2222", 32'(pending), 32'h1);
        push_frame(16'h2222, 4'b0000, 4'b1111, FL);

        // Frame 2: shows 2222; load 5678 exactly on the swap edge (bypass)
        wait_frame();
        chk("pending_after_swap2", 32'(pending), 32'h0);
        // Frame 3 is cut short by reset after its 9th cycle
        push_frame(16'h5678, 4'b0000, 4'b1111, 9);
        step(14);
        do_load(16'h5678);
        chk("pending_bypass", 32'(pending), 32'h0);

        // Frame 3: shows 5678; load 9999 then reset mid-frame
        wait_frame();
        step(3);
        do_load(16'h9999);
        chk("pending_after_9999", 32'(pending), 32'h1);
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_digit_bcd",   32'(digit_bcd),   32'h0);
        chk("mid_rst_digit_en",    32'(digit_en),    32'h0);
        chk("mid_rst_frame_start", 32'(frame_start), 32'h0);
        chk("mid_rst_pending",     32'(pending),     32'h0);
        chk("mid_rst_bcd_err",     32'(bcd_err),     32'h0);
        // Shadowed 9999 must be gone: two frames of 0
        push_frame(16'h0000, 4'b0000, 4'b0001, FL);
        push_frame(16'h0000, 4'b0000, 4'b0001, FL);
        rst_n = 1'b1;
        wait_frame();
        wait_frame();
        chk("pending_after_restart", 32'(pending), 32'h0);

        // Frame 5: load 00A3 -> slot 1 flags an error
        step(2);
        do_load(16'h00A3);
        push_frame(16'h00A3, 4'b0010, 4'b0011, FL);

        // Frame 6: load 0070
        wait_frame();
        step(2);
        do_load(16'h0070);
        push_frame(16'h0070, 4'b0000, 4'b0011, FL);

        // Frame 7: load 0000
        wait_frame();
        step(2);
        do_load(16'h0000);
        push_frame(16'h0000, 4'b0000, 4'b0001, FL);

        // Frame 8: let it run out, then stop checking
        wait_frame();
        step(FL - 1);
        mon_en = 1'b0;
        step(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Time-multiplexes a multi-digit packed-BCD value onto one shared 7-segment decoder. Each digit slot is selected in turn for REFRESH_DIV cycles: the block drives that slot's 4-bit code to the decoder and a one-hot digit enable to the display. New values are double-buffered and swapped only at frame boundaries, so a displayed number never shows a mix of old and new digits. Sits directly upstream of the 7-segment decoder; fed by counters or other BCD producers.

Parameters:
NUM_DIGITS, 4, number of digit slots (2..8)
REFRESH_DIV, 50000, clock cycles each digit stays selected (>=2)
CNT_W, $clog2(REFRESH_DIV), refresh counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
load  input  1  one-cycle strobe: capture bcd_in into the shadow register
bcd_in  input  4*NUM_DIGITS  packed BCD value; digit 0 in [3:0] (rightmost)
digit_bcd  output  4  code for the selected digit, to the decoder's 4-bit input
digit_en  output  NUM_DIGITS  one-hot active-high enable of the selected digit
frame_start  output  1  one-cycle pulse when slot 0 becomes selected
pending  output  1  shadow holds a value not yet shown
bcd_err  output  1  selected nibble > 9 (decoder output undefined)

Behaviour:
- Design has one clock and a synchronous active-low reset: rst_n sampled only on rising clk.
- Reset (rst_n=0 at an edge): refresh counter=0, index=0, display reg=0, shadow=0, pending=0, digit_bcd=0, digit_en=0, frame_start=0, bcd_err=0.
- All outputs are registered. First edge after reset release: digit_en=1 (slot 0), digit_bcd=display[3:0], frame_start=1.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. At the terminal count, index advances; index NUM_DIGITS-1 wraps to 0.
- Output latency is 1 cycle: digit_en/digit_bcd reflect the index registered on the previous edge.
- Each slot is enabled for exactly REFRESH_DIV consecutive cycles. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- load=1: shadow<=bcd_in, pending<=1. A load while pending=1 overwrites the shadow (last write wins). No backpressure; load is always accepted.
- Frame swap happens on the edge where index wraps to 0. If pending=1, display<=shadow and pending<=0.
- load on the same edge as a swap: display<=bcd_in directly (bypass) and pending<=0. The newest value wins.
- frame_start pulses together with the first cycle of slot 0.
- Nibbles >9 pass through unchanged and bcd_err=1 for that slot; no saturation.
- Reset mid-frame aborts the scan. The shadow is discarded and the display restarts at slot 0 with value 0.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: while a slot holds 0 and every higher slot also holds 0, its digit_en bit is forced 0 (display blank). Timing and index sequencing are unchanged. Slot 0 is never blanked, so value 0 shows "0".
- Undefined: all slots are always enabled in turn; zeros are shown.

Decomposition:
- Package disp_pkg: typedef bcd_t (4-bit), localparam BCD_MAX=9, function onehot(index).
- One sub-module, refresh_tick: parameterised terminal-count divider producing a 1-cycle tick. It is reusable for other refresh timing.
- Index, buffers and output regs stay in the top.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4; reset, then load bcd_in=16'h1234 -> first frame shows 0 in all slots. From the next frame: digit_bcd sequence 4,3,2,1 with digit_en 0001,0010,0100,1000, each held 4 cycles, frame_start every 16 cycles.
- Loads 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed at the next frame, never 1111. pending=1 between the load and the swap.
- load=16'h5678 on the exact swap edge -> slot 0 shows 8 in that frame; pending stays 0.
- Hold rst_n=0 mid-frame (slot 2, counter=1) for one edge -> all outputs 0 next cycle, then restart at slot 0 with display 0 and pending 0.
- Load 16'h00A3 -> bcd_err=1 only while slot 1 (nibble A) is selected; digit_bcd=4'hA.
- LEADING_ZERO_BLANK_EN defined, load 16'h0070 -> digit_en shows slots 0 and 1 only. Load 16'h0000 -> only slot 0 enabled; the others stay 0 for their whole 4-cycle windows.
